// File: rtl/wave_seq_pkg.sv
// Shared types and default widths for the waveform playlist sequencer.
// Entry layout matches the generator's func / freq_in control pins.
package wave_seq_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int FUNC_W_DEF = 3;
    localparam int FREQ_W_DEF = 5;
    localparam int DUR_W_DEF  = 16;

    typedef struct packed {
        logic [FUNC_W_DEF-1:0] func;
        logic [FREQ_W_DEF-1:0] freq;
        logic [DUR_W_DEF-1:0]  dur;
    } wave_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } wave_state_t;

endpackage

// File: rtl/wave_seq_table.sv
// Playlist register file: synchronous write, combinational read,
// asynchronous active-low clear of every entry.
module wave_seq_table
    import wave_seq_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int FUNC_W = FUNC_W_DEF,
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int DUR_W  = DUR_W_DEF,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [FUNC_W-1:0] wfunc_i,
    input  logic [FREQ_W-1:0] wfreq_i,
    input  logic [DUR_W-1:0]  wdur_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [FUNC_W-1:0] rfunc_o,
    output logic [FREQ_W-1:0] rfreq_o,
    output logic [DUR_W-1:0]  rdur_o
);

    logic [FUNC_W-1:0] func_q [DEPTH];
    logic [FREQ_W-1:0] freq_q [DEPTH];
    logic [DUR_W-1:0]  dur_q  [DEPTH];

    // Entry storage with whole-table clear on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                func_q[i] <= '0;
                freq_q[i] <= '0;
                dur_q[i]  <= '0;
            end
        end else if (we_i) begin
            func_q[waddr_i] <= wfunc_i;
            freq_q[waddr_i] <= wfreq_i;
            dur_q[waddr_i]  <= wdur_i;
        end
    end

    assign rfunc_o = func_q[raddr_i];
    assign rfreq_o = freq_q[raddr_i];
    assign rdur_o  = dur_q[raddr_i];

endmodule

// File: rtl/wave_sequencer.sv
// Playlist controller: steps through (func, freq, duration) entries and
// drives the waveform generator's func / freq_in / freq_load pins.
module wave_sequencer
    import wave_seq_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DUR_W  = DUR_W_DEF,
    parameter int FUNC_W = FUNC_W_DEF,
    parameter int FREQ_W = FREQ_W_DEF,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [FUNC_W-1:0] cfg_func,
    input  logic [FREQ_W-1:0] cfg_freq,
    input  logic [DUR_W-1:0]  cfg_dur,
    input  logic [IDX_W-1:0]  cfg_last,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic [FUNC_W-1:0] func,
    output logic [FREQ_W-1:0] freq_out,
    output logic              freq_load,
    output logic [IDX_W-1:0]  entry_idx,
    output logic              busy,
    output logic              done
);

    wave_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [DUR_W-1:0]  cnt_q, cnt_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [IDX_W-1:0]  rd_addr_s;
    logic [FUNC_W-1:0] rd_func_s;
    logic [FREQ_W-1:0] rd_freq_s;
    logic [DUR_W-1:0]  rd_dur_s;
    logic [DUR_W-1:0]  rd_hold_s;

    wave_seq_table #(
        .DEPTH  (DEPTH),
        .FUNC_W (FUNC_W),
        .FREQ_W (FREQ_W),
        .DUR_W  (DUR_W)
    ) u_table (
        .clk_i   (clk),
        .rst_n_i (reset),
        .we_i    (cfg_we),
        .waddr_i (cfg_addr),
        .wfunc_i (cfg_func),
        .wfreq_i (cfg_freq),
        .wdur_i  (cfg_dur),
        .raddr_i (rd_addr_s),
        .rfunc_o (rd_func_s),
        .rfreq_o (rd_freq_s),
        .rdur_o  (rd_dur_s)
    );

    // The only entry ever loaded next is idx+1, or entry 0 on start / wrap.
    always_comb begin
        rd_addr_s = '0;
        if (state_q == ST_PLAY && idx_q != last_q) begin
            rd_addr_s = idx_q + IDX_W'(1);
        end else begin
            rd_addr_s = '0;
        end
        rd_hold_s = (rd_dur_s == '0) ? '0 : rd_dur_s - DUR_W'(1);
    end

    // Next-state logic; stop outranks start and entry expiry.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        freq_d  = freq_q;
        load_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !stop) begin
                    state_d = ST_PLAY;
                    idx_d   = '0;
                    last_d  = cfg_last;
                    func_d  = rd_func_s;
                    freq_d  = rd_freq_s;
                    cnt_d   = rd_hold_s;
                    load_d  = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end else if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DUR_W'(1);
                end else if (idx_q == last_q && !loop) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d  = rd_addr_s;
                    func_d = rd_func_s;
                    freq_d = rd_freq_s;
                    cnt_d  = rd_hold_s;
                    load_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            func_q  <= '0;
            freq_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            func_q  <= func_d;
            freq_q  <= freq_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign func      = func_q;
    assign freq_out  = freq_q;
    assign freq_load = load_q;
    assign entry_idx = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Scoreboard bench for wave_sequencer: a playlist-level model queues the
// expected outputs per clock; a negedge monitor pops and compares them.
module tb_wave_sequencer;
    import wave_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = 3'd0;
    logic [2:0] cfg_func = 3'd0;
    logic [4:0] cfg_freq = 5'd0;
    logic [15:0] cfg_dur = 16'd0;
    logic [2:0] cfg_last = 3'd0;
    logic       loop = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] func;
    logic [4:0] freq_out;
    logic       freq_load;
    logic [2:0] entry_idx;
    logic       busy;
    logic       done;

    wave_sequencer dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_func(cfg_func), .cfg_freq(cfg_freq), .cfg_dur(cfg_dur),
        .cfg_last(cfg_last), .loop(loop), .start(start), .stop(stop),
        .func(func), .freq_out(freq_out), .freq_load(freq_load),
        .entry_idx(entry_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] func;
        logic [4:0] freq;
        logic       load;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: playlist position plus cycles left in the current entry.
    wave_entry_t m_tbl [8];
    logic [2:0]  m_idx, m_last, m_func;
    logic [4:0]  m_freq;
    logic        m_play, m_done, m_load;
    int          m_left;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_tbl[i] = '0;
        m_idx = 3'd0; m_last = 3'd0; m_func = 3'd0; m_freq = 5'd0;
        m_play = 1'b0; m_done = 1'b0; m_load = 1'b0; m_left = 0;
    endtask

    task automatic model_begin(input int i);
        m_idx  = 3'(i);
        m_func = m_tbl[i].func;
        m_freq = m_tbl[i].freq;
        m_load = 1'b1;
        m_left = (m_tbl[i].dur == 16'd0) ? 0 : int'(m_tbl[i].dur) - 1;
    endtask

    task automatic model_edge();
        exp_t e;
        m_load = 1'b0;
        if (stop) begin
            m_play = 1'b0;
        end else if (!m_play) begin
            if (start) begin
                m_last = cfg_last;
                m_done = 1'b0;
                m_play = 1'b1;
                model_begin(0);
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (m_idx == m_last) begin
            if (loop) model_begin(0);
            else begin
                m_play = 1'b0;
                m_done = 1'b1;
            end
        end else begin
            model_begin((int'(m_idx) + 1) % 8);
        end
        if (cfg_we) m_tbl[cfg_addr] = '{cfg_func, cfg_freq, cfg_dur};
        e = '{m_func, m_freq, m_load, m_idx, m_play, m_done};
        exp_q.push_back(e);
    endtask

    // Monitor: every clock the DUT presents one output tuple.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({func, freq_out, freq_load, entry_idx, busy, done} !==
                {e.func, e.freq, e.load, e.idx, e.busy, e.done}) begin
                failures++;
                $display("FAIL cycle_%0d got func=%0d freq=%0d load=%0b idx=%0d busy=%0b done=%0b want func=%0d freq=%0d load=%0b idx=%0d busy=%0b done=%0b",
                         cyc, func, freq_out, freq_load, entry_idx, busy, done,
                         e.func, e.freq, e.load, e.idx, e.busy, e.done);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic wr(input int a, input int f, input int q, input int d);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_func = 3'(f);
        cfg_freq = 5'(q); cfg_dur = 16'(d);
        step();
        cfg_we = 1'b0;
    endtask

    // Play from start for n cycles, returning a bitmap of freq_load cycles.
    task automatic play(input int n, output logic [31:0] mask);
        mask = '0;
        start = 1'b1;
        for (int c = 0; c < n; c++) begin
            step();
            start = 1'b0;
            if (freq_load === 1'b1) mask[c] = 1'b1;
        end
    endtask

    logic [31:0] mask;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {26'd0, func, freq_out, freq_load, entry_idx, busy, done}, 32'd0);
        reset = 1'b1;

        wr(0, 0, 31, 4); wr(1, 1, 10, 2); wr(2, 2, 5, 3);
        cfg_last = 3'd2; loop = 1'b0;
        play(12, mask);
        chk("noloop_loads", mask, 32'h051);
        chk("noloop_final", {func, freq_out, busy, done}, {3'd2, 5'd5, 1'b0, 1'b1});

        loop = 1'b1;
        play(16, mask);
        chk("loop_loads", mask, 32'hA251);
        chk("loop_busy", {busy, done}, {1'b1, 1'b0});
        stop = 1'b1; step(); stop = 1'b0;

        loop = 1'b0;
        wr(1, 1, 10, 0);
        play(10, mask);
        chk("zero_dur_loads", mask, 32'h031);
        wr(1, 1, 10, 2);

        play(5, mask);
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop_mid", {func, freq_load, busy, done}, {3'd1, 1'b0, 1'b0, 1'b0});
        start = 1'b1; stop = 1'b1; step(); idle_inputs();
        chk("start_stop_prio", {busy, freq_load}, {1'b0, 1'b0});
        step();

        loop = 1'b1;
        play(4, mask);
        wr(1, 3, 7, 2);
        repeat (14) step();
        stop = 1'b1; step(); stop = 1'b0;

        loop = 1'b0;
        play(3, mask);
        #2 reset = 1'b0;
        #1 chk("async_reset", {26'd0, func, freq_out, freq_load, entry_idx, busy, done}, 32'd0);
        @(negedge clk);
        model_reset();
        reset = 1'b1;
        cfg_last = 3'd7;
        play(10, mask);
        chk("zero_table_loads", mask, 32'h0FF);

        for (int i = 0; i < 700; i++) begin
            cfg_we   = ($urandom_range(0, 2) == 0);
            cfg_addr = 3'($urandom_range(0, 7));
            cfg_func = 3'($urandom_range(0, 7));
            cfg_freq = 5'($urandom_range(0, 31));
            cfg_dur  = 16'($urandom_range(0, 4));
            cfg_last = 3'($urandom_range(0, 7));
            start    = ($urandom_range(0, 5) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) loop = ~loop;
            step();
        end
        idle_inputs();
        step();
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
Playlist controller for the waveform generator top module. It holds a small table of (func, freq, duration) entries and steps through them automatically. For each entry it drives the generator's func and freq_in inputs and pulses freq_load, so the generator can run scripted waveform sequences without testbench or CPU intervention. It sits between the configuration interface and the generator's control pins.

Parameters:
DEPTH, 8, number of playlist entries (power of 2, minimum 2)
DUR_W, 16, width of per-entry duration in clock cycles
FUNC_W, 3, waveform select width (matches generator func)
FREQ_W, 5, frequency word width (matches generator freq_in)

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  log2(DEPTH)  table entry to write
cfg_func  in  FUNC_W  waveform select for the written entry
cfg_freq  in  FREQ_W  frequency word for the written entry
cfg_dur  in  DUR_W  hold time in cycles for the written entry
cfg_last  in  log2(DEPTH)  index of the final playlist entry; latched at start
loop  in  1  1 = wrap to entry 0 after the last entry
start  in  1  begin playback; single-cycle level sample
stop  in  1  abort playback
func  out  FUNC_W  to generator func
freq_out  out  FREQ_W  to generator freq_in
freq_load  out  1  to generator freq_load; one-cycle pulse per entry
entry_idx  out  log2(DEPTH)  entry currently playing
busy  out  1  playback active
done  out  1  sticky flag: last pass completed without loop

Behaviour:
- Reset (reset=0, asynchronous, effective immediately, including mid-playback):
  - state goes to IDLE.
  - func, freq_out, freq_load, entry_idx, busy and done are all 0.
  - All table entries are cleared to 0.
- All outputs are registered.
- States and transitions:
  - IDLE: on start=1 and stop=0, go to PLAY at entry 0.
  - PLAY: on stop=1, go to IDLE.
  - PLAY, last entry expired, loop=0: go to DONE.
  - PLAY, last entry expired, loop=1: stay in PLAY, reload entry 0.
  - DONE: behaves as IDLE, but done=1 remains set.
- Start timing:
  - start sampled high at edge k (in IDLE or DONE) takes effect at edge k.
  - From edge k: busy=1, done=0, entry_idx=0, func and freq_out = table[0], freq_load=1.
  - cfg_last is latched at edge k.
- Entry hold:
  - Entry i is held for D_i = max(cfg_dur_i, 1) cycles, counted from its freq_load cycle.
  - freq_load is high only in the first cycle of each entry.
  - The next entry follows with no gap cycle.
  - A down-counter of width DUR_W is loaded with D_i-1 at entry start; the entry advances when the count is 0.
- End of last entry (index = latched cfg_last):
  - loop is sampled in the cycle the counter reaches 0.
  - loop=1: entry 0 is reloaded with a freq_load pulse.
  - loop=0: next edge sets busy=0, done=1 and freq_load=0; func, freq_out and entry_idx hold their last values.
- stop=1 at any edge:
  - go to IDLE, busy=0, freq_load=0, done unchanged (not set).
  - func and freq_out hold their values.
  - stop has priority over a simultaneous start.
- start while busy is ignored.
- Table writes:
  - cfg_we is accepted in every state and written at the edge.
  - Entry values are sampled only at entry start, so a write to the currently playing entry takes effect on its next load.
  - A write coinciding with that entry's load cycle is not seen; the old value is used.
- Width rules:
  - The duration counter has no overflow; the maximum hold is 2^DUR_W-1 cycles.
  - entry_idx increments modulo DEPTH, but never passes the latched cfg_last.

Decomposition:
- Package wave_seq_pkg holds:
  - FUNC_W, FREQ_W and DUR_W defaults.
  - The entry struct {func, freq, dur}.
  - The state enum {IDLE, PLAY, DONE}.
- One sub-module, wave_seq_table: DEPTH-entry register file with synchronous write, combinational read and asynchronous active-low clear.
- FSM and counter stay in wave_sequencer.

Test Plan:
- Playback, no loop:
  - Stimulus: table e0=(0,31,4), e1=(1,10,2), e2=(2,5,3); cfg_last=2; loop=0; start at cycle 0.
  - Response: freq_load at cycles 0, 4 and 6; func goes 0→1→2; cycle 9: busy=0, done=1, func holds 2, freq_out holds 5.
- Looping:
  - Stimulus: same table, loop=1.
  - Response: freq_load at cycles 0, 4, 6, 9, 13, 15; done stays 0; busy stays 1.
- Zero duration:
  - Stimulus: e1 dur=0.
  - Response: e1 held exactly 1 cycle; freq_load at cycles 0, 4 and 5.
- Stop and start priority:
  - Stimulus: stop at cycle 5 during playback.
  - Response: cycle 5: busy=0, freq_load=0, done=0, func holds 1.
  - Stimulus: start and stop high in the same cycle from IDLE.
  - Response: remains IDLE.
- Reset mid-playback:
  - Stimulus: reset=0 during cycle 3 of e0.
  - Response: all outputs 0 immediately (before the next edge); a readback pass after release plays all-zero entries.
- Write during playback:
  - Stimulus: write e1=(3,7,2) while e1 is playing, loop=1.
  - Response: the current pass keeps func=1; the next pass shows func=3, freq_out=7.
